// File: rtl/one_bit_full_adder_pkg.sv
// Shared types and constants for the full-adder leaf cell and its carry-event counter.
`timescale 1ns/1ps
package one_bit_full_adder_pkg;

   localparam int CNT_WIDTH_DEF = 8;

   // Counter saturation value for the default counter width.
   localparam logic [CNT_WIDTH_DEF-1:0] CNT_SAT_DEF = {CNT_WIDTH_DEF{1'b1}};

   typedef struct packed {
      logic gen;
      logic prop;
      logic sum;
      logic cout;
   } fa_out_t;

endpackage

// File: rtl/one_bit_full_adder_half_adder.sv
// Half adder: o_sum = i_a ^ i_b, o_carry = i_a & i_b.
// Latency: combinational. Backpressure: none.
`timescale 1ns/1ps
module half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_sum,
   output logic o_carry
);

   assign o_sum   = i_a ^ i_b;
   assign o_carry = i_a & i_b;

endmodule

// File: rtl/one_bit_full_adder.sv
// Full adder leaf cell with gen/prop terms and a saturating carry-event counter.
// Latency: combinational outputs; one cycle when ONE_BIT_FULL_ADDER_REG_EN is defined. Backpressure: none.
`timescale 1ns/1ps
module one_bit_full_adder
   import one_bit_full_adder_pkg::*;
#(
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i0,
   input  logic                 i1,
   input  logic                 cin,
   output logic                 sum,
   output logic                 cout,
   output logic                 gen,
   output logic                 prop,
   output logic [CNT_WIDTH-1:0] carry_cnt
);

   localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX = {CNT_WIDTH{1'b1}};

   logic    w_prop;
   logic    w_gen;
   logic    w_sum;
   logic    w_c1;
   logic    w_cout;
   fa_out_t w_comb;
   fa_out_t w_out;

   logic [CNT_WIDTH-1:0] r_cnt;

   half_adder u_ha_ab (
      .i_a     (i0),
      .i_b     (i1),
      .o_sum   (w_prop),
      .o_carry (w_gen)
   );

   half_adder u_ha_pc (
      .i_a     (w_prop),
      .i_b     (cin),
      .o_sum   (w_sum),
      .o_carry (w_c1)
   );

   assign w_cout = w_gen | w_c1;
   assign w_comb = '{gen: w_gen, prop: w_prop, sum: w_sum, cout: w_cout};

`ifdef ONE_BIT_FULL_ADDER_REG_EN
   fa_out_t r_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out <= '0;
      end else begin
         r_out <= w_comb;
      end
   end

   assign w_out = r_out;
`else
   assign w_out = w_comb;
`endif

   // Counter watches whichever cout is presented at the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_out.cout && (r_cnt != LP_CNT_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign sum       = w_out.sum;
   assign cout      = w_out.cout;
   assign gen       = w_out.gen;
   assign prop      = w_out.prop;
   assign carry_cnt = r_cnt;

endmodule

// File: tb/tb_one_bit_full_adder.sv
// Scoreboard bench for one_bit_full_adder (default combinational build, 4-bit counter).
`timescale 1ns/1ps
module tb_one_bit_full_adder;

   localparam int TB_W   = 4;
   localparam int TB_MAX = (1 << TB_W) - 1;

   typedef struct {
      logic [2:0]      vec;
      logic            cout;
      logic            sum;
      logic            gen;
      logic            prop;
      logic [TB_W-1:0] cnt;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            i0  = 1'b0;
   logic            i1  = 1'b0;
   logic            cin = 1'b0;
   logic            sum;
   logic            cout;
   logic            gen;
   logic            prop;
   logic [TB_W-1:0] carry_cnt;

   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   ones   = 0;   // carry events the DUT will have sampled by the next edge

   one_bit_full_adder #(.CNT_WIDTH(TB_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .i0        (i0),
      .i1        (i1),
      .cin       (cin),
      .sum       (sum),
      .cout      (cout),
      .gen       (gen),
      .prop      (prop),
      .carry_cnt (carry_cnt)
   );

   always #12.5 clk = ~clk;

   function automatic exp_t model(input int a, input int b, input int c, input int events);
      exp_t e;
      int   total;
      total  = a + b + c;
      e.vec  = {a[0], b[0], c[0]};
      e.cout = (total >= 2);
      e.sum  = (total % 2) == 1;
      e.gen  = (a + b) == 2;
      e.prop = (a + b) == 1;
      e.cnt  = TB_W'((events > TB_MAX) ? TB_MAX : events);
      return e;
   endfunction

   // One vector per clock: drive after the edge, expect counter state from earlier edges.
   task automatic apply(input int a, input int b, input int c, input int ncyc);
      exp_t e;
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk);
         #1;
         i0  = a[0];
         i1  = b[0];
         cin = c[0];
         e   = model(a, b, c, ones);
         sb_q.push_back(e);
         if (e.cout) ones++;
      end
   endtask

   task automatic check_cnt(input string name, input int want);
      n_vec++;
      if (carry_cnt !== TB_W'(want)) begin
         n_fail++;
         $display("FAIL %s: carry_cnt got %0d want %0d", name, carry_cnt, want);
      end
   endtask

   // Pulse reset between edges, leaving (a,b,c) on the inputs.
   task automatic reset_pulse(input int a, input int b, input int c);
      exp_t e;
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_cnt("async_reset", 0);
      i0  = a[0];
      i1  = b[0];
      cin = c[0];
      #1;
      e = model(a, b, c, 0);
      n_vec++;
      if ({cout, sum, gen, prop} !== {e.cout, e.sum, e.gen, e.prop}) begin
         n_fail++;
         $display("FAIL comb_in_reset: {cout,sum,gen,prop} got %b want %b",
                  {cout, sum, gen, prop}, {e.cout, e.sum, e.gen, e.prop});
      end
      #2;
      rst  = 1'b0;
      ones = e.cout ? 1 : 0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_vec++;
         if ({cout, sum, gen, prop} !== {e.cout, e.sum, e.gen, e.prop} || carry_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL vec %b: {cout,sum,gen,prop}=%b cnt=%0d, want %b cnt=%0d",
                     e.vec, {cout, sum, gen, prop}, carry_cnt,
                     {e.cout, e.sum, e.gen, e.prop}, e.cnt);
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[8];
      order = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};

      #3;
      check_cnt("reset_state", 0);
      #2;
      rst = 1'b0;

      // Exhaustive sweep, 125 ns per pattern.
      foreach (order[k]) apply((order[k] >> 2) & 1, (order[k] >> 1) & 1, order[k] & 1, 5);

      // Counter: 5 carry edges then 3 quiet edges.
      apply(0, 0, 0, 1);
      reset_pulse(0, 0, 0);
      apply(1, 1, 0, 5);
      apply(0, 0, 0, 3);
      @(negedge clk);
      #1;
      check_cnt("count_5", 5);

      // Reach 7, then reset asynchronously with 111 presented.
      reset_pulse(0, 0, 0);
      apply(1, 1, 1, 7);
      apply(0, 0, 0, 1);
      @(negedge clk);
      #1;
      check_cnt("count_7", 7);
      reset_pulse(1, 1, 1);
      apply(1, 0, 1, 2);

      // Saturation.
      reset_pulse(0, 0, 0);
      for (int k = 0; k < 20; k++) apply(1, 1, $urandom_range(1, 0), 1);
      apply(0, 0, 0, 2);
      @(negedge clk);
      #1;
      check_cnt("saturate", TB_MAX);
      apply(1, 1, 1, 4);

      // Randomized traffic with occasional resets.
      reset_pulse(0, 0, 0);
      for (int k = 0; k < 300; k++) begin
         apply($urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0),
               $urandom_range(3, 1));
         if ($urandom_range(39, 0) == 0) reset_pulse($urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0));
      end

      repeat (3) @(negedge clk);
      #1;
      n_vec++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries never checked, want 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
